out_mux_tdm: RTL and testbench

Parametrised time-division output multiplexer for the IIR filter output stage.
- Captures NUM_CH signed fixed-point channel results on the slow (frame) enable.
- Re-quantises each channel to the output format with round-half-up.
- Emits channels one per fast enable in a TDM sequence, with channel tag, valid strobe, frame marker and an overrun flag.
- Sits between the multi-section filter core and the DAC/serial output interface.

---
 rtl/out_mux_tdm.sv | 160 ++++++++++++++++
 tb/tb_out_mux_tdm.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/out_mux_tdm.sv
// Time-division output multiplexer: captures NUM_CH signed channel results per frame,
// re-quantises with round-half-up and emits one channel per fast enable.
// Define OUT_MUX_TDM_SAT_EN to clamp to the output range and drive ovf; otherwise results wrap.
//
// state | meaning
// IDLE  | no frame being emitted; waits for enb with a frame available
// RUN   | emitting bank[slot]; at the last slot reloads or returns to IDLE
module out_mux_tdm #(
    parameter int NUM_CH   = 3,
    parameter int IN_W     = 36,
    parameter int IN_FRAC  = 27,
    parameter int OUT_W    = 11,
    parameter int OUT_FRAC = 3,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enb_frame,
    input  logic                     enb,
    input  logic [NUM_CH*IN_W-1:0]   in_bus,
    output logic signed [OUT_W-1:0]  Out1,
    output logic [CH_W-1:0]          out_ch,
    output logic                     out_valid,
    output logic                     frame_start,
    output logic                     miss,
    output logic                     ovf
);

    localparam int S = IN_FRAC - OUT_FRAC;
    localparam logic signed [IN_W:0] HALF = {{IN_W{1'b0}}, 1'b1} << (S - 1);

    generate
        if (NUM_CH < 2 || NUM_CH > 16 || IN_FRAC <= OUT_FRAC ||
            (IN_W - IN_FRAC) < (OUT_W - OUT_FRAC)) begin : g_param_check
            $error("out_mux_tdm: illegal parameter set");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    state_t                    state, state_nxt;
    logic [CH_W-1:0]           slot, slot_nxt;
    logic [NUM_CH*IN_W-1:0]    shadow, bank, src_vec;
    logic                      pending;
    logic                      load, advance, emit, frame_avail, last_slot;
    logic [IN_W-1:0]           sample;
    logic signed [OUT_W-1:0]   conv_q;

    always_comb begin
        state_nxt   = state;
        slot_nxt    = slot;
        load        = 1'b0;
        advance     = 1'b0;
        frame_avail = pending | enb_frame;
        last_slot   = (slot == CH_W'(NUM_CH - 1));
        if (enb) begin
            case (state)
                IDLE: begin
                    if (frame_avail) begin
                        load      = 1'b1;
                        state_nxt = RUN;
                        slot_nxt  = '0;
                    end
                end
                RUN: begin
                    if (!last_slot) begin
                        advance  = 1'b1;
                        slot_nxt = slot + 1'b1;
                    end else if (frame_avail) begin
                        load     = 1'b1;
                        slot_nxt = '0;
                    end else begin
                        state_nxt = IDLE;
                        slot_nxt  = '0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    slot_nxt  = '0;
                end
            endcase
        end
        emit = load | advance;
        // a frame arriving on the load edge bypasses the shadow register
        src_vec = load ? (enb_frame ? in_bus : shadow) : bank;
    end

    always_comb begin
        sample = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (slot_nxt == CH_W'(k)) sample = src_vec[k*IN_W +: IN_W];
        end
    end

`ifdef OUT_MUX_TDM_SAT_EN
    localparam int RW = IN_W + 1 - S;
    localparam logic signed [RW-1:0] Q_MAX = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [RW-1:0] Q_MIN = {{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [RW-1:0] rnd_q;
    logic                 sat_hit;

    always_comb begin
        rnd_q   = RW'(($signed({sample[IN_W-1], sample}) + HALF) >>> S);
        sat_hit = 1'b0;
        conv_q  = rnd_q[OUT_W-1:0];
        if (rnd_q > Q_MAX) begin
            conv_q  = Q_MAX[OUT_W-1:0];
            sat_hit = 1'b1;
        end else if (rnd_q < Q_MIN) begin
            conv_q  = Q_MIN[OUT_W-1:0];
            sat_hit = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) ovf <= 1'b0;
        else       ovf <= emit & sat_hit;
    end
`else
    always_comb begin
        conv_q = OUT_W'(($signed({sample[IN_W-1], sample}) + HALF) >>> S);
    end

    assign ovf = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            slot        <= '0;
            shadow      <= '0;
            bank        <= '0;
            pending     <= 1'b0;
            miss        <= 1'b0;
            Out1        <= '0;
            out_ch      <= '0;
            out_valid   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state <= state_nxt;
            slot  <= slot_nxt;
            if (enb_frame) begin
                shadow  <= in_bus;
                pending <= !load;
                if (pending && !load) miss <= 1'b1;
            end else if (load) begin
                pending <= 1'b0;
            end
            if (load) bank <= src_vec;
            out_valid   <= emit;
            frame_start <= emit && (slot_nxt == '0);
            if (emit) begin
                Out1   <= conv_q;
                out_ch <= slot_nxt;
            end
        end
    end

endmodule

// File: tb/tb_out_mux_tdm.sv
// Self-checking bench for out_mux_tdm: directed scenarios plus randomized traffic
// compared against an arithmetic reference model of the TDM output stage.
module tb_out_mux_tdm;

    localparam int NUM_CH   = 3;
    localparam int IN_W     = 36;
    localparam int IN_FRAC  = 27;
    localparam int OUT_W    = 11;
    localparam int OUT_FRAC = 3;
    localparam int CH_W     = 2;
    localparam int S        = IN_FRAC - OUT_FRAC;
    localparam longint ONE  = longint'(1) << IN_FRAC;
    localparam int Q_MAX    = (1 << (OUT_W - 1)) - 1;
    localparam int Q_MIN    = -(1 << (OUT_W - 1));

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     enb_frame;
    logic                     enb;
    logic [NUM_CH*IN_W-1:0]   in_bus;
    logic signed [OUT_W-1:0]  Out1;
    logic [CH_W-1:0]          out_ch;
    logic                     out_valid;
    logic                     frame_start;
    logic                     miss;
    logic                     ovf;

    int tests_run    = 0;
    int tests_failed = 0;

    longint cur_in[NUM_CH];
    longint m_shadow[NUM_CH];
    longint m_bank[NUM_CH];
    bit     m_pending, m_run, m_valid, m_fs, m_miss, m_ovf;
    int     m_slot, m_out1, m_ch;

    out_mux_tdm #(
        .NUM_CH(NUM_CH), .IN_W(IN_W), .IN_FRAC(IN_FRAC), .OUT_W(OUT_W), .OUT_FRAC(OUT_FRAC)
    ) dut (
        .clk(clk), .reset(reset), .enb_frame(enb_frame), .enb(enb), .in_bus(in_bus),
        .Out1(Out1), .out_ch(out_ch), .out_valid(out_valid), .frame_start(frame_start),
        .miss(miss), .ovf(ovf)
    );

    always #5 clk = ~clk;

    function automatic int conv_ref(input longint x, output bit clamped);
        longint div, num, r;
        div = longint'(1) << S;
        num = x + div / 2;
        r = num / div;
        if (num < 0 && (num % div) != 0) r = r - 1;
        clamped = 1'b0;
`ifdef OUT_MUX_TDM_SAT_EN
        if (r > Q_MAX) begin
            r = Q_MAX; clamped = 1'b1;
        end else if (r < Q_MIN) begin
            r = Q_MIN; clamped = 1'b1;
        end
`else
        r = ((r % 2048) + 2048) % 2048;
        if (r > Q_MAX) r = r - 2048;
`endif
        return int'(r);
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < NUM_CH; k++) begin
            m_shadow[k] = 0;
            m_bank[k]   = 0;
        end
        m_pending = 0; m_run = 0; m_valid = 0; m_fs = 0; m_miss = 0; m_ovf = 0;
        m_slot = 0; m_out1 = 0; m_ch = 0;
    endfunction

    function automatic void model_step(input bit ef, input bit en);
        bit avail, ld, emit, clamped;
        avail = m_pending || ef;
        ld = 0;
        emit = 0;
        if (en) begin
            if (!m_run) ld = avail;
            else if (m_slot < NUM_CH - 1) begin
                m_slot++;
                emit = 1;
            end else if (avail) ld = 1;
            else begin
                m_run = 0;
                m_slot = 0;
            end
        end
        if (ld) begin
            for (int k = 0; k < NUM_CH; k++) m_bank[k] = ef ? cur_in[k] : m_shadow[k];
            m_run = 1;
            m_slot = 0;
            emit = 1;
        end
        if (ef) begin
            if (m_pending && !ld) m_miss = 1;
            for (int k = 0; k < NUM_CH; k++) m_shadow[k] = cur_in[k];
            m_pending = !ld;
        end else if (ld) begin
            m_pending = 0;
        end
        m_valid = emit;
        m_fs    = emit && (m_slot == 0);
        m_ovf   = 0;
        if (emit) begin
            m_out1 = conv_ref(m_bank[m_slot], clamped);
            m_ch   = m_slot;
            m_ovf  = clamped;
        end
    endfunction

    task automatic cycle(input bit ef, input bit en);
        enb_frame = ef;
        enb = en;
        for (int k = 0; k < NUM_CH; k++) in_bus[k*IN_W +: IN_W] = cur_in[k][IN_W-1:0];
        @(posedge clk);
        model_step(ef, en);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enb_frame = 1'b0;
        enb = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (Out1 !== '0 || out_ch !== '0 || out_valid !== 1'b0 || frame_start !== 1'b0 ||
            miss !== 1'b0 || ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: got Out1=%0d ch=%0d v=%b fs=%b miss=%b ovf=%b, expected all 0",
                     Out1, out_ch, out_valid, frame_start, miss, ovf);
        end
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b1);
            tests_run++;
            if (out_valid !== 1'b0 || Out1 !== '0 || out_ch !== '0 || miss !== 1'b0) begin
                tests_failed++;
                $display("FAIL idle_no_frame cyc %0d: got v=%b Out1=%0d ch=%0d miss=%b, expected 0/0/0/0",
                         i, out_valid, Out1, out_ch, miss);
            end
        end
    endtask

    task automatic test_single_frame();
        int got_v[$], got_c[$], got_f[$];
        int exp_v[3] = '{12, -16, 1};
        do_reset();
        cur_in[0] = 3 * (ONE / 2);
        cur_in[1] = -2 * ONE;
        cur_in[2] = ONE / 16;
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, (i % 3) == 2);
            if (out_valid === 1'b1) begin
                got_v.push_back(int'(Out1));
                got_c.push_back(int'(out_ch));
                got_f.push_back(int'(frame_start));
            end
        end
        tests_run++;
        if (got_v.size() != 3) begin
            tests_failed++;
            $display("FAIL single_frame_count: got %0d strobes, expected 3", got_v.size());
        end
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (k >= got_v.size() || got_v[k] != exp_v[k] || got_c[k] != k || got_f[k] != (k == 0)) begin
                tests_failed++;
                $display("FAIL single_frame_slot%0d: got Out1=%0d ch=%0d fs=%0d, expected %0d/%0d/%0d",
                         k, (k < got_v.size()) ? got_v[k] : 0, (k < got_c.size()) ? got_c[k] : 0,
                         (k < got_f.size()) ? got_f[k] : 0, exp_v[k], k, (k == 0));
            end
        end
    endtask

    task automatic test_bypass();
        cur_in[0] = ONE / 2;
        cur_in[1] = ONE;
        cur_in[2] = -ONE;
        cycle(1'b1, 1'b1);
        tests_run++;
        if (out_valid !== 1'b1 || Out1 !== 11'sd4 || out_ch !== 2'd0 || frame_start !== 1'b1) begin
            tests_failed++;
            $display("FAIL bypass_emit: got v=%b Out1=%0d ch=%0d fs=%b, expected 1/4/0/1",
                     out_valid, Out1, out_ch, frame_start);
        end
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        tests_run++;
        if (out_valid !== 1'b1 || Out1 !== -11'sd8 || out_ch !== 2'd2) begin
            tests_failed++;
            $display("FAIL bypass_ch2: got v=%b Out1=%0d ch=%0d, expected 1/-8/2", out_valid, Out1, out_ch);
        end
        cycle(1'b0, 1'b1);
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bypass_no_pending: got out_valid=%b, expected 0", out_valid);
        end
    endtask

    task automatic test_gapless();
        int n_emit = 0;
        do_reset();
        for (int i = 0; i < 45; i++) begin
            if (i % 9 == 0) begin
                cur_in[0] = ONE / 4 + longint'(i / 9) * ONE;
                cur_in[1] = longint'($urandom_range(0, 4000)) * (ONE / 64);
                cur_in[2] = -longint'($urandom_range(0, 4000)) * (ONE / 64);
            end
            cycle((i % 9) == 0, (i % 3) == 2);
            tests_run++;
            if (out_valid !== ((i % 3) == 2)) begin
                tests_failed++;
                $display("FAIL gapless_valid cyc %0d: got %b, expected %b", i, out_valid, (i % 3) == 2);
            end
            if (out_valid === 1'b1) begin
                tests_run++;
                if (int'(out_ch) != n_emit % 3 || (n_emit % 3 == 0 && int'(Out1) != 2 + 8 * (n_emit / 3))) begin
                    tests_failed++;
                    $display("FAIL gapless_seq emit %0d: got ch=%0d Out1=%0d, expected ch=%0d ch0val=%0d",
                             n_emit, out_ch, Out1, n_emit % 3, 2 + 8 * (n_emit / 3));
                end
                n_emit++;
            end
        end
        tests_run++;
        if (n_emit != 15 || miss !== 1'b0) begin
            tests_failed++;
            $display("FAIL gapless_total: got %0d emits miss=%b, expected 15 emits miss=0", n_emit, miss);
        end
    endtask

    task automatic test_overrun();
        int got[$];
        int exp_v[6] = '{8, 8, 8, 24, 24, 24};
        do_reset();
        for (int i = 0; i < 18; i++) begin
            if (i == 0 || i == 3 || i == 6)
                for (int k = 0; k < NUM_CH; k++) cur_in[k] = longint'(i / 3 + 1) * ONE;
            cycle(i == 0 || i == 3 || i == 6, (i % 3) == 2);
            if (out_valid === 1'b1) got.push_back(int'(Out1));
        end
        for (int k = 0; k < 6; k++) begin
            tests_run++;
            if (k >= got.size() || got[k] != exp_v[k]) begin
                tests_failed++;
                $display("FAIL overrun_seq %0d: got %0d, expected %0d", k, (k < got.size()) ? got[k] : 9999, exp_v[k]);
            end
        end
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1);
        tests_run++;
        if (miss !== 1'b1 || got.size() != 6) begin
            tests_failed++;
            $display("FAIL overrun_sticky: got miss=%b emits=%0d, expected miss=1 emits=6", miss, got.size());
        end
    endtask

    task automatic test_conv();
        int exp_v[3];
        bit exp_o[3];
`ifdef OUT_MUX_TDM_SAT_EN
        exp_v = '{1023, 0, 1023};
        exp_o = '{1'b1, 1'b0, 1'b0};
`else
        exp_v = '{-448, 0, 1023};
        exp_o = '{1'b0, 1'b0, 1'b0};
`endif
        do_reset();
        cur_in[0] = 200 * ONE;
        cur_in[1] = -(ONE / 16);
        cur_in[2] = 64'sd17166854554;
        for (int k = 0; k < 3; k++) begin
            cycle(k == 0, 1'b1);
            tests_run++;
            if (out_valid !== 1'b1 || int'(Out1) != exp_v[k] || ovf !== exp_o[k]) begin
                tests_failed++;
                $display("FAIL conv_ch%0d: got v=%b Out1=%0d ovf=%b, expected 1/%0d/%b",
                         k, out_valid, Out1, ovf, exp_v[k], exp_o[k]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        for (int k = 0; k < NUM_CH; k++) cur_in[k] = longint'(k + 1) * ONE;
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        tests_run++;
        if (miss !== 1'b1 || out_ch !== 2'd1 || Out1 !== 11'sd16) begin
            tests_failed++;
            $display("FAIL midframe_pre: got miss=%b ch=%0d Out1=%0d, expected 1/1/16", miss, out_ch, Out1);
        end
        do_reset();
        tests_run++;
        if (Out1 !== '0 || out_ch !== '0 || out_valid !== 1'b0 || frame_start !== 1'b0 ||
            miss !== 1'b0 || ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL midframe_reset: got Out1=%0d ch=%0d v=%b fs=%b miss=%b ovf=%b, expected all 0",
                     Out1, out_ch, out_valid, frame_start, miss, ovf);
        end
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1);
            tests_run++;
            if (out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL midframe_discard cyc %0d: got out_valid=%b, expected 0", i, out_valid);
            end
        end
        cycle(1'b1, 1'b1);
        tests_run++;
        if (out_valid !== 1'b1 || Out1 !== 11'sd8 || out_ch !== 2'd0) begin
            tests_failed++;
            $display("FAIL midframe_resume: got v=%b Out1=%0d ch=%0d, expected 1/8/0", out_valid, Out1, out_ch);
        end
    endtask

    task automatic test_random(input int ef_div, input int cycles);
        do_reset();
        for (int i = 0; i < cycles; i++) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if ($urandom_range(0, 1) == 1) cur_in[k] = longint'({$urandom(), $urandom()}) >>> 28;
                else cur_in[k] = longint'(int'($urandom_range(0, 20000)) - 10000) * (ONE / 64);
            end
            cycle($urandom_range(0, ef_div - 1) == 0, $urandom_range(0, 1) == 1);
            tests_run++;
            if (int'(Out1) != m_out1 || int'(out_ch) != m_ch || out_valid !== m_valid ||
                frame_start !== m_fs || miss !== m_miss || ovf !== m_ovf) begin
                tests_failed++;
                $display("FAIL random cyc %0d: got Out1=%0d ch=%0d v=%b fs=%b miss=%b ovf=%b, expected %0d/%0d/%b/%b/%b/%b",
                         i, Out1, out_ch, out_valid, frame_start, miss, ovf,
                         m_out1, m_ch, m_valid, m_fs, m_miss, m_ovf);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        enb_frame = 1'b0;
        enb = 1'b0;
        in_bus = '0;
        for (int k = 0; k < NUM_CH; k++) cur_in[k] = 0;
        model_reset();
        test_reset();
        test_single_frame();
        test_bypass();
        test_gapless();
        test_overrun();
        test_conv();
        test_reset_midframe();
        test_random(6, 400);
        test_random(3, 400);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
